// File: rtl/parallel_tx_pkg.sv
// rtl/parallel_tx_pkg.sv - shared state encodings and default strobe timing for the parallel link
package parallel_tx_pkg;

  localparam int BYTE_W = 8;

  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_HIGH_CYCLES  = 2;
  localparam int DEF_LOW_CYCLES   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/parallel_tx_phase_timer.sv
// rtl/parallel_tx_phase_timer.sv - loadable down counter; expired while the count sits at 1
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Holding at 1 keeps expired asserted while a phase waits on something else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count > W'(1)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/parallel_tx.sv
// rtl/parallel_tx.sv - strobed 8-bit parallel transmitter, MSB byte first; PARALLEL_TX_ACK_EN adds par_ack handshake
module parallel_tx
  import parallel_tx_pkg::*;
#(
  parameter int BYTES        = 8,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int HIGH_CYCLES  = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES   = DEF_LOW_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTE_W*BYTES-1:0] response,
  input  logic                  send,
`ifdef PARALLEL_TX_ACK_EN
  input  logic                  par_ack,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [BYTE_W-1:0]     data,
  output logic                  par_clk
);

  localparam int WORD_W = BYTE_W * BYTES;
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW     = $clog2(max3(SETUP_CYCLES, HIGH_CYCLES, LOW_CYCLES) + 1);

  tx_state_t         state, state_n;
  logic [WORD_W-1:0] shreg, shreg_n, shreg_shl;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [BYTE_W-1:0] data_n;
  logic              pclk_n, busy_n, done_n;
  logic              t_load, t_expired;
  logic [TW-1:0]     t_val;
  logic              high_go, low_go;

  assign shreg_shl = shreg << BYTE_W;

`ifdef PARALLEL_TX_ACK_EN
  assign high_go = t_expired && par_ack;
  assign low_go  = t_expired && !par_ack;
`else
  assign high_go = t_expired;
  assign low_go  = t_expired;
`endif

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      data    <= '0;
      par_clk <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      idx     <= idx_n;
      data    <= data_n;
      par_clk <= pclk_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    data_n  = data;
    pclk_n  = par_clk;
    busy_n  = busy;
    done_n  = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    case (state)
      IDLE: begin
        pclk_n = 1'b0;
        if (send) begin
          shreg_n = response;
          idx_n   = '0;
          data_n  = response[WORD_W-1 -: BYTE_W];
          busy_n  = 1'b1;
          t_load  = 1'b1;
          t_val   = TW'(SETUP_CYCLES);
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (t_expired) begin
          pclk_n  = 1'b1;
          t_load  = 1'b1;
          t_val   = TW'(HIGH_CYCLES);
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (high_go) begin
          pclk_n  = 1'b0;
          t_load  = 1'b1;
          t_val   = TW'(LOW_CYCLES);
          state_n = LOW;
        end
      end
      LOW: begin
        if (low_go) begin
          if (idx == IDX_W'(BYTES - 1)) begin
            state_n = DONE;
          end else begin
            // Next byte goes out only here, so data never moves under a high strobe.
            shreg_n = shreg_shl;
            idx_n   = idx + IDX_W'(1);
            data_n  = shreg_shl[WORD_W-1 -: BYTE_W];
            t_load  = 1'b1;
            t_val   = TW'(SETUP_CYCLES);
            state_n = SETUP;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        pclk_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_parallel_tx.sv
// tb/tb_parallel_tx.sv - directed bench for parallel_tx (default and ack-handshake builds)
module tb_parallel_tx;

  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W2 = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] resp_a;
  logic        send_a, busy_a, done_a, pclk_a;
  logic [7:0]  data_a;
  logic [15:0] resp_b;
  logic        send_b, busy_b, done_b, pclk_b;
  logic [7:0]  data_b;
`ifdef PARALLEL_TX_ACK_EN
  logic        ack_a = 1'b0;
  logic        ack_b = 1'b0;
  int          ack_cnt = 0;
  int          ack_rises = 0;
  int          high_len = 0;
  int          high_bad = 0;
  int          high_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  logic       pq_a = 1'b0, pq_b = 1'b0;
  logic [7:0] dq_a, dq_b;
  int         done_cnt_a = 0;

  always #5 clk = ~clk;

  parallel_tx dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .response (resp_a),
    .send     (send_a),
`ifdef PARALLEL_TX_ACK_EN
    .par_ack  (ack_a),
`endif
    .busy     (busy_a),
    .done     (done_a),
    .data     (data_a),
    .par_clk  (pclk_a)
  );

  parallel_tx #(.BYTES(2), .SETUP_CYCLES(1), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .response (resp_b),
    .send     (send_b),
`ifdef PARALLEL_TX_ACK_EN
    .par_ack  (ack_b),
`endif
    .busy     (busy_b),
    .done     (done_b),
    .data     (data_b),
    .par_clk  (pclk_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe-edge capture and data-stability watch, sampled mid-cycle
  always @(negedge clk) begin
    if (pclk_a) begin
      checks++;
      assert (data_a === dq_a) else begin
        errors++;
        $error("FAIL stable_a observed=%0h expected=%0h", data_a, dq_a);
      end
    end
    if (pclk_b) begin
      checks++;
      assert (data_b === dq_b) else begin
        errors++;
        $error("FAIL stable_b observed=%0h expected=%0h", data_b, dq_b);
      end
    end
    if (pclk_a && !pq_a) cap_a.push_back(data_a);
    if (pclk_b && !pq_b) cap_b.push_back(data_b);
    if (done_a) done_cnt_a++;
`ifdef PARALLEL_TX_ACK_EN
    if (pclk_a) high_len++;
    if (!pclk_a && pq_a) begin
      high_cnt++;
      if (high_len != 5) high_bad++;
      high_len = 0;
    end
    if (pclk_a !== ack_a) begin
      ack_cnt++;
      if (ack_cnt == 5) begin
        ack_a   = pclk_a;
        ack_cnt = 0;
        if (ack_a) ack_rises++;
      end
    end else begin
      ack_cnt = 0;
    end
`endif
    pq_a = pclk_a;
    dq_a = data_a;
    pq_b = pclk_b;
    dq_b = data_b;
  end

  function automatic logic [63:0] pack_a(input int first, input int cnt);
    logic [63:0] v = '0;
    for (int k = 0; k < cnt; k++)
      if (first + k < cap_a.size()) v = {v[55:0], cap_a[first + k]};
    return v;
  endfunction

  task automatic send_word_a(input logic [63:0] w, input int limit, output int n, output int rise);
    @(negedge clk);
    resp_a = w;
    send_a = 1'b1;
    n = 0;
    rise = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      send_a = 1'b0;
      if (pclk_a && rise == 0) rise = i;
      if (done_a) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n, rise, d0, d1, d2;
    rst_n  = 1'b0;
    send_a = 1'b0;
    send_b = 1'b0;
    resp_a = '0;
    resp_b = '0;
    repeat (3) @(negedge clk);
    check("rst_data", data_a, 0);
    check("rst_pclk", pclk_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_pclk", pclk_b, 0);
    check("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef PARALLEL_TX_ACK_EN
    cap_a.delete();
    send_word_a(W1, 300, n, rise);
    check("ack_done_lat", n, 98);
    check("ack_rise_lat", rise, 3);
    check("ack_rises", ack_rises, 8);
    check("ack_high_len", high_bad, 0);
    check("ack_high_cnt", high_cnt, 8);
    check("ack_at_done", ack_a, 0);
    @(negedge clk);
    check("ack_cap_n", cap_a.size(), 8);
    check("ack_word", pack_a(0, 8), W1);
`else
    // Single word with default timing
    cap_a.delete();
    send_word_a(W1, 100, n, rise);
    check("t1_done_lat", n, 50);
    check("t1_rise_lat", rise, 3);
    check("t1_busy_at_done", busy_a, 0);
    @(negedge clk);
    check("t1_busy_after", busy_a, 0);
    check("t1_done_after", done_a, 0);
    check("t1_cap_n", cap_a.size(), 8);
    check("t1_word", pack_a(0, 8), W1);

    // send held high across two words
    cap_a.delete();
    d1 = 0;
    d2 = 0;
    @(negedge clk);
    resp_a = W1;
    send_a = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) resp_a = W2;
      if (done_a) begin
        if (d1 == 0) d1 = i;
        else begin
          d2 = i;
          send_a = 1'b0;
          break;
        end
      end
    end
    send_a = 1'b0;
    check("t2_done1", d1, 50);
    check("t2_done2", d2, 100);
    repeat (2) @(negedge clk);
    check("t2_busy", busy_a, 0);
    check("t2_cap_n", cap_a.size(), 16);
    check("t2_word1", pack_a(0, 8), W1);
    check("t2_word2", pack_a(8, 8), W2);

    // send pulse mid-word is ignored
    cap_a.delete();
    d0 = done_cnt_a;
    n = 0;
    @(negedge clk);
    resp_a = W1;
    send_a = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      send_a = (i == 10);
      if (i == 10) resp_a = W2;
      if (done_a) begin
        n = i;
        break;
      end
    end
    send_a = 1'b0;
    check("t3_done_lat", n, 50);
    repeat (10) @(negedge clk);
    check("t3_cap_n", cap_a.size(), 8);
    check("t3_word", pack_a(0, 8), W1);
    check("t3_done_cnt", done_cnt_a - d0, 1);
    check("t3_busy", busy_a, 0);

    // Asynchronous reset during HIGH of byte 3
    cap_a.delete();
    d0 = done_cnt_a;
    @(negedge clk);
    resp_a = W1;
    send_a = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      send_a = 1'b0;
    end
    check("t4_pre_high", pclk_a, 1);
    check("t4_pre_data", data_a, 8'h67);
    #1 rst_n = 1'b0;
    #1;
    check("t4_rst_pclk", pclk_a, 0);
    check("t4_rst_data", data_a, 0);
    check("t4_rst_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_no_done", done_cnt_a - d0, 0);
    check("t4_cap_n", cap_a.size(), 4);
    check("t4_partial", pack_a(0, 4), {32'h0, W1[63:32]});
    cap_a.delete();
    send_word_a(W2, 100, n, rise);
    check("t4_fresh_lat", n, 50);
    @(negedge clk);
    check("t4_fresh_word", pack_a(0, 8), W2);

    // Minimum timing, two-byte instance
    cap_b.delete();
    n = 0;
    rise = 0;
    @(negedge clk);
    resp_b = 16'hA55A;
    send_b = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      send_b = 1'b0;
      if (pclk_b && rise == 0) rise = i;
      if (done_b) begin
        n = i;
        break;
      end
    end
    check("t5_done_lat", n, 8);
    check("t5_rise_lat", rise, 2);
    @(negedge clk);
    check("t5_cap_n", cap_b.size(), 2);
    if (cap_b.size() == 2) check("t5_word", {cap_b[0], cap_b[1]}, 16'hA55A);
    check("t5_busy", busy_b, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
